branch_ctrl: RTL and testbench

- Upstream neighbour of the program counter. Decodes the current instruction's control-flow request and drives the PC's Branch/Target inputs in the same cycle.
- Holds a writable jump-target lookup table (LUT) and a hardware return-address stack for call/return.
- Freezes the PC on halt by self-branching, because the PC has no stall input.

---
 rtl/branch_pkg.sv | 18 +
 rtl/branch_ctrl_if.sv | 39 +++
 rtl/branch_ctrl_ret_stack.sv | 62 ++++++
 rtl/branch_ctrl.sv | 125 ++++++++++++
 tb/tb_branch_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and defaults for the branch controller.
// Ops are listed in ascending priority order.
package branch_pkg;

  localparam int A_DEF     = 10;
  localparam int LW_DEF    = 5;
  localparam int DEPTH_DEF = 8;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_BR,
    OP_JMP,
    OP_CALL,
    OP_RET,
    OP_HALT
  } br_op_t;

endpackage

// File: rtl/branch_ctrl_if.sv
// Control-flow bus between the instruction decoder and the PC.
// The master side is the decoder; the slave side is branch_ctrl.
interface branch_ctrl_if #(
  parameter int A  = 10,
  parameter int LW = 5
);

  logic          Start;
  logic [A-1:0]  PC;
  logic          BrEn;
  logic          Cond;
  logic          JmpEn;
  logic          CallEn;
  logic          RetEn;
  logic          HaltEn;
  logic [LW-1:0] LutIdx;
  logic          LutWe;
  logic [LW-1:0] LutWIdx;
  logic [A-1:0]  LutWData;
  logic          Branch;
  logic [A-1:0]  Target;
  logic          Done;
  logic          StackErr;

  modport master (
    output Start, PC, BrEn, Cond, JmpEn,
    output CallEn, RetEn, HaltEn, LutIdx,
    output LutWe, LutWIdx, LutWData,
    input  Branch, Target, Done, StackErr
  );

  modport slave (
    input  Start, PC, BrEn, Cond, JmpEn,
    input  CallEn, RetEn, HaltEn, LutIdx,
    input  LutWe, LutWIdx, LutWData,
    output Branch, Target, Done, StackErr
  );

endinterface

// File: rtl/branch_ctrl_ret_stack.sv
// Hardware return-address stack with overflow/underflow pulses.
// A push on a full stack or a pop on an empty one is dropped.
module ret_stack #(
  parameter int A     = 10,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic         pop,
  input  logic [A-1:0] din,
  output logic [A-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err_ovf,
  output logic         err_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int SW = PW + 1;

  logic [SW-1:0] sp_q, sp_d;
  logic [SW-1:0] sp_m1;
  logic [A-1:0]  mem_q [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign empty   = (sp_q == '0);
  assign full    = (sp_q == SW'(DEPTH));
  assign do_push = push && !full && !clear;
  assign do_pop  = pop && !empty && !clear;
  assign err_ovf = push && full && !clear;
  assign err_unf = pop && empty && !clear;
  assign sp_m1   = sp_q - SW'(1);
  assign top     = empty ? '0 : mem_q[sp_m1[PW-1:0]];

  always_comb begin
    sp_d = sp_q;
    unique case (1'b1)
      clear:   sp_d = '0;
      do_push: sp_d = sp_q + SW'(1);
      do_pop:  sp_d = sp_m1;
      default: sp_d = sp_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      sp_q <= sp_d;
      if (do_push) begin
        mem_q[sp_q[PW-1:0]] <= din;
      end
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch controller: decodes control-flow ops into PC Branch/Target,
// with a writable jump-target LUT, return stack and sticky halt.
module branch_ctrl
  import branch_pkg::*;
#(
  parameter int A     = A_DEF,
  parameter int LW    = LW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic         Clk,
  input  logic         Reset_n,
  branch_ctrl_if.slave bus
);

  localparam int NLUT = 2 ** LW;

  logic [A-1:0] lut_q [NLUT];
  logic [A-1:0] lut_rd;
  logic         done_q, done_d;
  logic         err_q, err_d;
  br_op_t       op;
  logic         branch;
  logic [A-1:0] target;
  logic [A-1:0] ret_addr;
  logic [A-1:0] stk_top;
  logic         stk_empty;
  logic         stk_full;
  logic         stk_ovf;
  logic         stk_unf;
  logic         stk_unused;

  assign lut_rd     = lut_q[bus.LutIdx];
  assign ret_addr   = bus.PC + A'(1);
  assign stk_unused = stk_full;

  ret_stack #(
    .A     (A),
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (Clk),
    .rst_n   (Reset_n),
    .clear   (bus.Start),
    .push    (op == OP_CALL),
    .pop     (op == OP_RET),
    .din     (ret_addr),
    .top     (stk_top),
    .empty   (stk_empty),
    .full    (stk_full),
    .err_ovf (stk_ovf),
    .err_unf (stk_unf)
  );

  // Start masks every op, so nothing below fires on a restart cycle.
  always_comb begin
    op = OP_NONE;
    if (!bus.Start) begin
      priority case (1'b1)
        done_q || bus.HaltEn: op = OP_HALT;
        bus.RetEn:            op = OP_RET;
        bus.CallEn:           op = OP_CALL;
        bus.JmpEn:            op = OP_JMP;
        bus.BrEn:             op = OP_BR;
        default:              op = OP_NONE;
      endcase
    end
  end

  always_comb begin
    branch = 1'b0;
    target = lut_rd;
    unique case (op)
      OP_HALT: begin
        branch = 1'b1;
        target = bus.PC;
      end
      OP_RET: begin
        branch = !stk_empty;
        target = stk_empty ? lut_rd : stk_top;
      end
      OP_CALL: branch = 1'b1;
      OP_JMP:  branch = 1'b1;
      OP_BR:   branch = bus.Cond;
      default: branch = 1'b0;
    endcase
    if (!Reset_n) begin
      branch = 1'b0;
      target = '0;
    end
  end

  always_comb begin
    done_d = done_q || (op == OP_HALT);
    err_d  = err_q || stk_ovf || stk_unf;
    if (bus.Start) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NLUT; i++) begin
        lut_q[i] <= '0;
      end
    end else if (bus.LutWe) begin
      lut_q[bus.LutWIdx] <= bus.LutWData;
    end
  end

  assign bus.Branch   = branch;
  assign bus.Target   = target;
  assign bus.Done     = done_q;
  assign bus.StackErr = err_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl: vector table plus
// hand-written overflow and mid-run reset sequences.
module tb_branch_ctrl;

  localparam int A  = 10;
  localparam int LW = 5;

  localparam logic [5:0] NO   = 6'b000000;
  localparam logic [5:0] BR0  = 6'b100000;
  localparam logic [5:0] BR1  = 6'b110000;
  localparam logic [5:0] JMP  = 6'b001000;
  localparam logic [5:0] CALL = 6'b000100;
  localparam logic [5:0] RET  = 6'b000010;
  localparam logic [5:0] HALT = 6'b000001;

  typedef struct {
    logic          st;
    logic [A-1:0]  pc;
    logic [5:0]    ops;
    logic [LW-1:0] idx;
    logic          we;
    logic [LW-1:0] widx;
    logic [A-1:0]  wd;
    logic          eb;
    logic          chk_t;
    logic [A-1:0]  et;
    logic          ed;
    logic          ee;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset_n;
  int   total = 0;
  int   bad   = 0;
  vec_t tbl [26];

  branch_ctrl_if #(.A(A), .LW(LW)) bif ();

  branch_ctrl #(.A(A), .LW(LW), .DEPTH(8)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bif.slave)
  );

  always #5 Clk = ~Clk;

  function automatic vec_t mk(
    logic st, logic [A-1:0] pc, logic [5:0] ops,
    logic [LW-1:0] idx, logic we, logic [LW-1:0] widx,
    logic [A-1:0] wd, logic eb, logic chk_t,
    logic [A-1:0] et, logic ed, logic ee
  );
    vec_t v;
    v.st = st; v.pc = pc; v.ops = ops; v.idx = idx;
    v.we = we; v.widx = widx; v.wd = wd; v.eb = eb;
    v.chk_t = chk_t; v.et = et; v.ed = ed; v.ee = ee;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic st, logic [A-1:0] pc,
                       logic [5:0] ops, logic [LW-1:0] idx,
                       logic we, logic [LW-1:0] widx,
                       logic [A-1:0] wd);
    bif.Start    = st;
    bif.PC       = pc;
    bif.BrEn     = ops[5];
    bif.Cond     = ops[4];
    bif.JmpEn    = ops[3];
    bif.CallEn   = ops[2];
    bif.RetEn    = ops[1];
    bif.HaltEn   = ops[0];
    bif.LutIdx   = idx;
    bif.LutWe    = we;
    bif.LutWIdx  = widx;
    bif.LutWData = wd;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic op_chk(string nm, logic [A-1:0] pc,
                        logic [5:0] ops, logic [LW-1:0] idx,
                        logic eb, logic [A-1:0] et, logic ee);
    drive(1'b0, pc, ops, idx, 1'b0, '0, '0);
    @(negedge Clk);
    chk({nm, ".branch"}, 32'(bif.Branch), 32'(eb));
    if (eb) chk({nm, ".target"}, 32'(bif.Target), 32'(et));
    chk({nm, ".err"}, 32'(bif.StackErr), 32'(ee));
    tick();
  endtask

  initial begin
    tbl[0]  = mk(0, 10'h000, NO,   0, 1, 3, 10'h120, 0, 1, 10'h000, 0, 0);
    tbl[1]  = mk(0, 10'h000, JMP,  3, 0, 0, 10'h000, 1, 1, 10'h120, 0, 0);
    tbl[2]  = mk(0, 10'h000, JMP,  3, 1, 3, 10'h050, 1, 1, 10'h120, 0, 0);
    tbl[3]  = mk(0, 10'h000, JMP,  3, 0, 0, 10'h000, 1, 1, 10'h050, 0, 0);
    tbl[4]  = mk(0, 10'h000, NO,   0, 1, 1, 10'h040, 0, 1, 10'h000, 0, 0);
    tbl[5]  = mk(0, 10'h000, BR0,  1, 0, 0, 10'h000, 0, 1, 10'h040, 0, 0);
    tbl[6]  = mk(0, 10'h000, BR1,  1, 0, 0, 10'h000, 1, 1, 10'h040, 0, 0);
    tbl[7]  = mk(0, 10'h000, NO,   0, 1, 2, 10'h200, 0, 1, 10'h000, 0, 0);
    tbl[8]  = mk(0, 10'h000, NO,   0, 1, 4, 10'h300, 0, 1, 10'h000, 0, 0);
    tbl[9]  = mk(0, 10'h010, CALL, 2, 0, 0, 10'h000, 1, 1, 10'h200, 0, 0);
    tbl[10] = mk(0, 10'h205, CALL, 4, 0, 0, 10'h000, 1, 1, 10'h300, 0, 0);
    tbl[11] = mk(0, 10'h300, RET,  0, 0, 0, 10'h000, 1, 1, 10'h206, 0, 0);
    tbl[12] = mk(0, 10'h207, RET,  0, 0, 0, 10'h000, 1, 1, 10'h011, 0, 0);
    tbl[13] = mk(0, 10'h012, RET,  0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0);
    tbl[14] = mk(0, 10'h013, NO,   0, 0, 0, 10'h000, 0, 1, 10'h000, 0, 1);
    tbl[15] = mk(1, 10'h014, JMP,  3, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1);
    tbl[16] = mk(0, 10'h000, NO,   3, 0, 0, 10'h000, 0, 1, 10'h050, 0, 0);
    tbl[17] = mk(0, 10'h3FF, CALL, 2, 0, 0, 10'h000, 1, 1, 10'h200, 0, 0);
    tbl[18] = mk(0, 10'h200, RET,  0, 0, 0, 10'h000, 1, 1, 10'h000, 0, 0);
    tbl[19] = mk(0, 10'h07F, HALT, 3, 0, 0, 10'h000, 1, 1, 10'h07F, 0, 0);
    tbl[20] = mk(0, 10'h07F, JMP,  3, 0, 0, 10'h000, 1, 1, 10'h07F, 1, 0);
    tbl[21] = mk(0, 10'h07F, CALL, 2, 1, 5, 10'h155, 1, 1, 10'h07F, 1, 0);
    tbl[22] = mk(1, 10'h07F, JMP,  3, 0, 0, 10'h000, 0, 0, 10'h000, 1, 0);
    tbl[23] = mk(0, 10'h000, JMP,  5, 0, 0, 10'h000, 1, 1, 10'h155, 0, 0);
    tbl[24] = mk(0, 10'h001, RET,  0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0);
    tbl[25] = mk(1, 10'h002, NO,   0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1);

    // reset: outputs forced low even with a halt asserted
    Reset_n = 1'b0;
    drive(1'b0, 10'h055, HALT, 3, 1'b0, '0, '0);
    tick();
    @(negedge Clk);
    chk("rst.branch", 32'(bif.Branch), 32'd0);
    chk("rst.target", 32'(bif.Target), 32'd0);
    tick();
    Reset_n = 1'b1;
    drive(1'b0, '0, NO, 0, 1'b0, '0, '0);
    @(negedge Clk);
    chk("rst.done", 32'(bif.Done), 32'd0);
    chk("rst.err", 32'(bif.StackErr), 32'd0);
    tick();

    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].st, tbl[i].pc, tbl[i].ops, tbl[i].idx,
            tbl[i].we, tbl[i].widx, tbl[i].wd);
      @(negedge Clk);
      chk($sformatf("v%0d.branch", i), 32'(bif.Branch), 32'(tbl[i].eb));
      if (tbl[i].chk_t)
        chk($sformatf("v%0d.target", i), 32'(bif.Target), 32'(tbl[i].et));
      chk($sformatf("v%0d.done", i), 32'(bif.Done), 32'(tbl[i].ed));
      chk($sformatf("v%0d.err", i), 32'(bif.StackErr), 32'(tbl[i].ee));
      tick();
    end

    // overflow: ninth call still branches, push dropped
    for (int i = 0; i < 9; i++) begin
      op_chk($sformatf("ovf.call%0d", i), 10'(10'h100 + i),
             CALL, 2, 1'b1, 10'h200, 1'b0);
    end
    op_chk("ovf.ret", 10'h200, RET, 0, 1'b1, 10'h108, 1'b1);
    drive(1'b1, '0, NO, 0, 1'b0, '0, '0);
    tick();
    op_chk("unf.ret", 10'h000, RET, 0, 1'b0, 10'h000, 1'b0);
    op_chk("unf.after", 10'h001, NO, 0, 1'b0, 10'h000, 1'b1);
    drive(1'b1, '0, NO, 0, 1'b0, '0, '0);
    tick();

    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      op_chk($sformatf("mid.call%0d", i), 10'(10'h020 + i),
             CALL, 2, 1'b1, 10'h200, 1'b0);
    end
    op_chk("mid.halt", 10'h040, HALT, 0, 1'b1, 10'h040, 1'b0);
    drive(1'b0, 10'h040, NO, 0, 1'b0, '0, '0);
    @(negedge Clk);
    chk("mid.done", 32'(bif.Done), 32'd1);
    tick();
    Reset_n = 1'b0;
    drive(1'b0, 10'h040, JMP, 3, 1'b1, 6, 10'h1AB);
    @(negedge Clk);
    chk("mid.rst.branch", 32'(bif.Branch), 32'd0);
    chk("mid.rst.target", 32'(bif.Target), 32'd0);
    tick();
    Reset_n = 1'b1;
    drive(1'b0, 10'h000, JMP, 3, 1'b0, '0, '0);
    @(negedge Clk);
    chk("post.done", 32'(bif.Done), 32'd0);
    chk("post.err", 32'(bif.StackErr), 32'd0);
    chk("post.branch", 32'(bif.Branch), 32'd1);
    chk("post.lut3", 32'(bif.Target), 32'd0);
    tick();
    op_chk("post.lut6", 10'h001, JMP, 6, 1'b1, 10'h000, 1'b0);
    op_chk("post.ret", 10'h002, RET, 0, 1'b0, 10'h000, 1'b0);
    op_chk("post.err2", 10'h003, NO, 0, 1'b0, 10'h000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
